// File: rtl/cpu_bus_sequencer.sv
// ============================================================================
// Module      : cpu_bus_sequencer
// Description : Serialises 32-bit CPU bus accesses onto an 8-bit pin interface
//               (header byte, 4 address bytes, optional 4 read-data bytes).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module cpu_bus_sequencer #(
    parameter int         TIMEOUT  = 255,
    parameter logic [7:0] HDR_MARK = 8'hFF
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        cpu_req,
    input  logic        cpu_we,
    input  logic [31:0] cpu_addr,
    input  logic [31:0] cpu_wdata,
    output logic [31:0] cpu_rdata,
    output logic        cpu_done,
    output logic        cpu_err,
    output logic        busy,
    output logic [7:0]  addr_out,
    output logic [7:0]  data_out,
    output logic [7:0]  data_oe,
    input  logic [7:0]  data_in,
    output logic        strobe,
    input  logic        ext_rdy
);

    localparam logic [2:0] c_ST_IDLE  = 3'd0;
    localparam logic [2:0] c_ST_HDR   = 3'd1;
    localparam logic [2:0] c_ST_ADDR  = 3'd2;
    localparam logic [2:0] c_ST_WAIT  = 3'd3;
    localparam logic [2:0] c_ST_RDATA = 3'd4;
    localparam logic [2:0] c_ST_DONE  = 3'd5;

    localparam logic [15:0] c_TMO_LAST = (TIMEOUT == 0) ? 16'd0 : 16'(TIMEOUT - 1);

    logic [2:0]  r_state;
    logic [2:0]  w_state_nxt;
    logic [1:0]  r_idx;
    logic [15:0] r_timer;
    logic        r_we;
    logic [31:0] r_addr;
    logic [31:0] r_wdata;
    logic [31:0] r_rdata;
    logic        r_err;
    logic        w_tmo;

    // Timer equals the last permitted WAIT cycle; disabled when TIMEOUT is 0.
    assign w_tmo = (TIMEOUT != 0) && (r_timer == c_TMO_LAST);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= c_ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        cpu_done    = 1'b0;
        cpu_err     = 1'b0;
        busy        = (r_state != c_ST_IDLE);
        addr_out    = 8'h00;
        data_out    = 8'h00;
        data_oe     = 8'h00;
        strobe      = 1'b0;
        case (r_state)
            c_ST_IDLE: begin
                if (cpu_req) begin
                    w_state_nxt = c_ST_HDR;
                end
            end
            c_ST_HDR: begin
                addr_out    = HDR_MARK;
                data_out    = {7'b0, r_we};
                data_oe     = 8'hFF;
                strobe      = 1'b1;
                w_state_nxt = c_ST_ADDR;
            end
            c_ST_ADDR: begin
                addr_out = r_addr[{r_idx, 3'b000} +: 8];
                strobe   = 1'b1;
                if (r_we) begin
                    data_out = r_wdata[{r_idx, 3'b000} +: 8];
                    data_oe  = 8'hFF;
                end
                if (r_idx == 2'd3) begin
                    w_state_nxt = r_we ? c_ST_DONE : c_ST_WAIT;
                end
            end
            c_ST_WAIT: begin
                // A ready device takes priority over an expiring timer.
                if (ext_rdy) begin
                    w_state_nxt = c_ST_RDATA;
                end else if (w_tmo) begin
                    w_state_nxt = c_ST_DONE;
                end
            end
            c_ST_RDATA: begin
                strobe = 1'b1;
                if (r_idx == 2'd3) begin
                    w_state_nxt = c_ST_DONE;
                end
            end
            c_ST_DONE: begin
                cpu_done    = 1'b1;
                cpu_err     = r_err;
                w_state_nxt = c_ST_IDLE;
            end
            default: begin
                w_state_nxt = c_ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_idx   <= 2'd0;
            r_timer <= 16'd0;
            r_we    <= 1'b0;
            r_addr  <= 32'd0;
            r_wdata <= 32'd0;
            r_rdata <= 32'd0;
            r_err   <= 1'b0;
        end else begin
            r_timer <= 16'd0;
            case (r_state)
                c_ST_IDLE: begin
                    r_idx <= 2'd0;
                    if (cpu_req) begin
                        r_we    <= cpu_we;
                        r_addr  <= cpu_addr;
                        r_wdata <= cpu_wdata;
                        r_err   <= 1'b0;
                    end
                end
                c_ST_ADDR: begin
                    r_idx <= (r_idx == 2'd3) ? 2'd0 : r_idx + 2'd1;
                end
                c_ST_WAIT: begin
                    if (!ext_rdy) begin
                        if (w_tmo) begin
                            r_err   <= 1'b1;
                            r_rdata <= 32'd0;
                        end else begin
                            r_timer <= r_timer + 16'd1;
                        end
                    end
                end
                c_ST_RDATA: begin
                    r_rdata[{r_idx, 3'b000} +: 8] <= data_in;
                    r_idx <= (r_idx == 2'd3) ? 2'd0 : r_idx + 2'd1;
                end
                default: begin
                    r_idx <= 2'd0;
                end
            endcase
        end
    end

    assign cpu_rdata = r_rdata;

endmodule

`default_nettype wire

// File: tb/tb_cpu_bus_sequencer.sv
// ============================================================================
// Module      : tb_cpu_bus_sequencer
// Description : Scoreboard bench for cpu_bus_sequencer with directed accesses.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_cpu_bus_sequencer;

    localparam int         c_TIMEOUT  = 8;
    localparam logic [7:0] c_HDR_MARK = 8'hFF;

    logic        clk = 1'b0;
    logic        rst;
    logic        cpu_req;
    logic        cpu_we;
    logic [31:0] cpu_addr;
    logic [31:0] cpu_wdata;
    logic [31:0] cpu_rdata;
    logic        cpu_done;
    logic        cpu_err;
    logic        busy;
    logic [7:0]  addr_out;
    logic [7:0]  data_out;
    logic [7:0]  data_oe;
    logic [7:0]  data_in;
    logic        strobe;
    logic        ext_rdy;

    typedef struct {
        logic [31:0] rd;
        logic        err;
        int          cyc;
    } done_t;

    logic [23:0] pin_q[$];
    done_t       done_q[$];
    int          cyc = 0;
    int          n_tests = 0;
    int          n_fail = 0;
    logic [31:0] last_rd;

    cpu_bus_sequencer #(
        .TIMEOUT  (c_TIMEOUT),
        .HDR_MARK (c_HDR_MARK)
    ) u_dut (
        .clk       (clk),
        .rst       (rst),
        .cpu_req   (cpu_req),
        .cpu_we    (cpu_we),
        .cpu_addr  (cpu_addr),
        .cpu_wdata (cpu_wdata),
        .cpu_rdata (cpu_rdata),
        .cpu_done  (cpu_done),
        .cpu_err   (cpu_err),
        .busy      (busy),
        .addr_out  (addr_out),
        .data_out  (data_out),
        .data_oe   (data_oe),
        .data_in   (data_in),
        .strobe    (strobe),
        .ext_rdy   (ext_rdy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc++;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at cycle %0d: got %0h, expected %0h", name, cyc, act, exp);
        end
    endtask

    // Monitor: pops expected pin bytes on every strobe and results on every done.
    always @(negedge clk) begin
        logic [23:0] e_pin;
        done_t       e_done;
        if (strobe === 1'b1) begin
            if (pin_q.size() == 0) begin
                chk("unexpected_strobe", {40'd0, addr_out, data_out, data_oe}, 64'hDEAD);
            end else begin
                e_pin = pin_q.pop_front();
                chk("pins{addr,data,oe}", {40'd0, addr_out, data_out, data_oe}, {40'd0, e_pin});
            end
        end
        if (cpu_done === 1'b1) begin
            if (done_q.size() == 0) begin
                chk("unexpected_done", 64'd1, 64'd0);
            end else begin
                e_done = done_q.pop_front();
                chk("cpu_rdata", {32'd0, cpu_rdata}, {32'd0, e_done.rd});
                chk("cpu_err", {63'd0, cpu_err}, {63'd0, e_done.err});
                chk("done_cycle", 64'(cyc), 64'(e_done.cyc));
            end
        end
    end

    task automatic push_write(input logic [31:0] a, input logic [31:0] w, input int done_cyc);
        pin_q.push_back({c_HDR_MARK, 8'h01, 8'hFF});
        for (int i = 0; i < 4; i++) pin_q.push_back({a[8*i +: 8], w[8*i +: 8], 8'hFF});
        done_q.push_back('{last_rd, 1'b0, done_cyc});
    endtask

    task automatic do_write(input logic [31:0] a, input logic [31:0] w);
        int c0;
        c0 = cyc;
        push_write(a, w, c0 + 6);
        cpu_we = 1'b1; cpu_addr = a; cpu_wdata = w; cpu_req = 1'b1;
        for (int n = 0; n < 30; n++) begin
            @(negedge clk);
            cpu_req = 1'b0;
            if (cpu_done === 1'b1) break;
        end
        @(negedge clk);
    endtask

    task automatic do_read(input logic [31:0] a, input logic [31:0] rd, input int extra, input bit tmo);
        int c0, k;
        logic [31:0] exp_rd;
        c0 = cyc;
        exp_rd = tmo ? 32'd0 : rd;
        pin_q.push_back({c_HDR_MARK, 8'h00, 8'hFF});
        for (int i = 0; i < 4; i++) pin_q.push_back({a[8*i +: 8], 8'h00, 8'h00});
        if (!tmo) for (int i = 0; i < 4; i++) pin_q.push_back(24'h000000);
        done_q.push_back('{exp_rd, tmo, tmo ? c0 + 14 : c0 + 11 + extra});
        last_rd = exp_rd;
        cpu_we = 1'b0; cpu_addr = a; cpu_req = 1'b1;
        ext_rdy = !tmo && (extra == 0);
        for (int n = 0; n < 40; n++) begin
            @(negedge clk);
            k = cyc - c0;
            cpu_req = 1'b0;
            ext_rdy = !tmo && (extra == 0 || k >= 6 + extra);
            if (k >= 7 + extra && k <= 10 + extra) data_in = rd[8*(k-7-extra) +: 8];
            else data_in = 8'h5A;
            if (cpu_done === 1'b1) break;
        end
        @(negedge clk);
        ext_rdy = 1'b0;
    endtask

    task automatic check_reset_state(input string tag);
        chk({tag, "_busy"},  {63'd0, busy},     64'd0);
        chk({tag, "_done"},  {63'd0, cpu_done}, 64'd0);
        chk({tag, "_err"},   {63'd0, cpu_err},  64'd0);
        chk({tag, "_oe"},    {56'd0, data_oe},  64'd0);
        chk({tag, "_addr"},  {56'd0, addr_out}, 64'd0);
        chk({tag, "_strobe"},{63'd0, strobe},   64'd0);
        chk({tag, "_rdata"}, {32'd0, cpu_rdata},64'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish, got none, expected finish");
        $fatal(1, "global timeout");
    end

    initial begin
        int c0, k;
        rst = 1'b1; cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = 32'd0; cpu_wdata = 32'd0;
        data_in = 8'h00; ext_rdy = 1'b0; last_rd = 32'd0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        check_reset_state("reset1");
        @(negedge clk);

        do_write(32'h1234_5678, 32'hCAFE_BABE);
        do_read(32'h0000_0010, 32'hDEAD_BEEF, 0, 1'b0);

        // Reset while idle with read data held.
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        last_rd = 32'd0;
        check_reset_state("reset2");
        @(negedge clk);

        do_read(32'h0000_0044, 32'h1111_1111, 0, 1'b1);
        do_read(32'h0000_0020, 32'hA5A5_3C3C, 2, 1'b0);
        do_read(32'h8000_0001, 32'h0BAD_F00D, 7, 1'b0);

        // Reset during ADDR index 2 of a write.
        c0 = cyc;
        pin_q.push_back({c_HDR_MARK, 8'h01, 8'hFF});
        pin_q.push_back({8'hD0, 8'h44, 8'hFF});
        pin_q.push_back({8'hC0, 8'h33, 8'hFF});
        pin_q.push_back({8'hB0, 8'h22, 8'hFF});
        cpu_we = 1'b1; cpu_addr = 32'hA0B0_C0D0; cpu_wdata = 32'h1122_3344; cpu_req = 1'b1;
        for (int n = 0; n < 4; n++) begin
            @(negedge clk);
            cpu_req = 1'b0;
        end
        k = cyc - c0;
        chk("abort_at_idx2_cycle", 64'(k), 64'd4);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        last_rd = 32'd0;
        chk("abort_busy",   {63'd0, busy},    64'd0);
        chk("abort_oe",     {56'd0, data_oe}, 64'd0);
        chk("abort_strobe", {63'd0, strobe},  64'd0);
        repeat (8) @(negedge clk);
        do_write(32'h0000_00F0, 32'h0102_0304);

        // Back-to-back with cpu_req held high and address changing while busy.
        c0 = cyc;
        push_write(32'h0000_1000, 32'h5555_AAAA, c0 + 6);
        push_write(32'h2000_3000, 32'h7777_8888, c0 + 13);
        cpu_we = 1'b1; cpu_addr = 32'h0000_1000; cpu_wdata = 32'h5555_AAAA; cpu_req = 1'b1;
        for (int n = 0; n < 14; n++) begin
            @(negedge clk);
            k = cyc - c0;
            if (k == 2) begin cpu_addr = 32'hDEAD_0000; cpu_wdata = 32'h0; end
            if (k == 6) begin cpu_addr = 32'h2000_3000; cpu_wdata = 32'h7777_8888; end
            if (k == 7) chk("b2b_idle_gap_busy", {63'd0, busy}, 64'd0);
            if (k == 8) begin
                chk("b2b_hdr_busy", {63'd0, busy}, 64'd1);
                cpu_req = 1'b0;
            end
        end
        repeat (3) @(negedge clk);

        chk("pin_queue_drained",  64'(pin_q.size()),  64'd0);
        chk("done_queue_drained", 64'(done_q.size()), 64'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
